// File: rtl/dual_crack_pkg.sv
// Shared types and constants for the dual RC4 key-search controller.
//   KEY_W / TK_W / ADDR_W : key, test-key and plaintext address widths
//   START0 / START1 / INCR: engine key-stream setup (even / odd keys, step 2)
//   RD_WAIT               : cycles an engine read address is held before its data is sampled
package dual_crack_pkg;
  localparam int KEY_W  = 24;
  localparam int TK_W   = 25;
  localparam int ADDR_W = 8;

  localparam logic [TK_W-1:0] START0 = 25'd0;
  localparam logic [TK_W-1:0] START1 = 25'd1;
  localparam logic [TK_W-1:0] INCR   = 25'd2;

  localparam int RD_WAIT = 2;
  localparam int CNT_W   = $clog2(RD_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE, RSTENG, START, GO, WAIT, LEN, CPY, DONE
  } state_t;

  typedef enum logic [1:0] {
    CP_IDLE, CP_READ, CP_WRITE
  } cp_phase_t;
endpackage

// File: rtl/dual_crack_ctrl_copy.sv
// Read-wait-write sequencer that moves the winning engine's length-prefixed
// plaintext into the shared pt memory.
//   start/sel    : begin a copy from engine sel (sampled on start)
//   rddata       : both engines' read data, {eng1, eng0}
//   dc_addr      : both engines' read addresses, only the selected one moves
//   pt_*         : shared memory write port
//   hdr_wr       : the length byte (pt[0]) is being written this cycle
//   done         : the final byte is being written this cycle
module crack_copy
  import dual_crack_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sel,
  input  logic [2*ADDR_W-1:0] rddata,
  output logic [2*ADDR_W-1:0] dc_addr,
  output logic [ADDR_W-1:0]   pt_addr,
  output logic [ADDR_W-1:0]   pt_wrdata,
  output logic                pt_wren,
  output logic                hdr_wr,
  output logic                done
);
  cp_phase_t          phase_q, phase_d;
  logic               sel_q;
  logic [ADDR_W:0]    idx_q;  // one extra bit so len=255 never wraps
  logic [ADDR_W-1:0]  len_q;
  logic [ADDR_W-1:0]  data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  rd_sel;
  logic               last;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_WAIT - 1);

  assign rd_sel = sel_q ? rddata[2*ADDR_W-1:ADDR_W] : rddata[ADDR_W-1:0];
  assign last   = (idx_q == {1'b0, len_q});

  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      CP_IDLE:  if (start) phase_d = CP_READ;
      CP_READ:  if (cnt_q == '0) phase_d = CP_WRITE;
      CP_WRITE: phase_d = last ? CP_IDLE : CP_READ;
      default:  phase_d = CP_IDLE;
    endcase
  end

  always_comb begin
    dc_addr = '0;
    if (phase_q != CP_IDLE) begin
      if (sel_q) dc_addr = {idx_q[ADDR_W-1:0], {ADDR_W{1'b0}}};
      else       dc_addr = {{ADDR_W{1'b0}}, idx_q[ADDR_W-1:0]};
    end
  end

  // Write enable is also gated by rst_n so a write in flight dies with reset.
  assign pt_wren   = (phase_q == CP_WRITE) && rst_n;
  assign pt_addr   = idx_q[ADDR_W-1:0];
  assign pt_wrdata = data_q;
  assign hdr_wr    = (phase_q == CP_WRITE) && (idx_q == '0);
  assign done      = (phase_q == CP_WRITE) && last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= CP_IDLE;
      sel_q   <= 1'b0;
      idx_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      unique case (phase_q)
        CP_IDLE: if (start) begin
          sel_q <= sel;
          idx_q <= '0;
          cnt_q <= CNT_LOAD;
        end
        CP_READ: begin
          if (cnt_q == '0) begin
            data_q <= rd_sel;
            if (idx_q == '0) len_q <= rd_sel;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        CP_WRITE: if (!last) begin
          idx_q <= idx_q + 1'b1;
          cnt_q <= CNT_LOAD;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/dual_crack_ctrl.sv
// Control stage for two parallel RC4 key-search engines. Restarts both engines
// on an even/odd key split, takes the first success, copies the winner's
// length-prefixed plaintext into pt memory and reports the key.
//   en / rdy             : start request, accepted only while idle
//   key / key_valid      : winning key (0 unless valid)
//   eng_rst_n / eng_en   : per-engine reset (low = held) and start pulse
//   eng_start / eng_incr : constant key-stream setup
//   eng_rdy/key/kv       : engine status
//   eng_dc_addr/rddata   : engine plaintext read port
//   pt_addr/wrdata/wren  : shared pt memory write port
//
// state  | meaning
// IDLE   | rdy=1, waiting for en
// RSTENG | both engines in reset for one cycle (reload start keys)
// START  | one-cycle start pulse to both engines
// GO     | wait for both engines to leave idle
// WAIT   | wait for a success, or both exhausted
// LEN    | read and write the length byte of the winner
// CPY    | copy bytes 1..len of the winner
// DONE   | capture the winner's key
module dual_crack_ctrl
  import dual_crack_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                rdy,
  output logic [KEY_W-1:0]    key,
  output logic                key_valid,
  output logic [1:0]          eng_rst_n,
  output logic [1:0]          eng_en,
  output logic [2*TK_W-1:0]   eng_start,
  output logic [TK_W-1:0]     eng_incr,
  input  logic [1:0]          eng_rdy,
  input  logic [2*KEY_W-1:0]  eng_key,
  input  logic [1:0]          eng_kv,
  output logic [2*ADDR_W-1:0] eng_dc_addr,
  input  logic [2*ADDR_W-1:0] eng_dc_rddata,
  output logic [ADDR_W-1:0]   pt_addr,
  output logic [ADDR_W-1:0]   pt_wrdata,
  output logic                pt_wren
);
  state_t     state_q, state_d;
  logic       win_q;
  logic [1:0] hold_q;  // bit i set: engine i is the loser and stays in reset
  logic       win_found, win_idx;
  logic       cp_start, cp_hdr, cp_done;
  logic [1:0] eng_rst_int;

  assign eng_start = {START1, START0};
  assign eng_incr  = INCR;

  // Engine 0 is checked first, so it wins a same-cycle tie.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 1'b0;
    if (eng_rdy[0] && eng_kv[0]) begin
      win_found = 1'b1;
    end else if (eng_rdy[1] && eng_kv[1]) begin
      win_found = 1'b1;
      win_idx   = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cp_start = 1'b0;
    unique case (state_q)
      IDLE:   if (en) state_d = RSTENG;
      RSTENG: state_d = START;
      START:  state_d = GO;
      GO:     if (eng_rdy == 2'b00) state_d = WAIT;
      WAIT: begin
        if (win_found) begin
          cp_start = 1'b1;
          state_d  = LEN;
        end else if (eng_rdy == 2'b11) begin
          state_d = IDLE;
        end
      end
      LEN: begin
        if (cp_done)     state_d = DONE;
        else if (cp_hdr) state_d = CPY;
      end
      CPY:    if (cp_done) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rdy         = (state_q == IDLE);
  assign eng_en      = (state_q == START) ? 2'b11 : 2'b00;
  assign eng_rst_int = (state_q == RSTENG) ? 2'b00 : ~hold_q;
  // rst_n feeds straight through so engines reset together with this block.
  assign eng_rst_n   = {2{rst_n}} & eng_rst_int;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      hold_q    <= 2'b00;
      key       <= '0;
      key_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && en) begin
        key       <= '0;
        key_valid <= 1'b0;
      end
      if (state_q == RSTENG) hold_q <= 2'b00;
      if (cp_start) begin
        win_q  <= win_idx;
        hold_q <= win_idx ? 2'b01 : 2'b10;
      end
      if (state_q == DONE) begin
        key       <= win_q ? eng_key[2*KEY_W-1:KEY_W] : eng_key[KEY_W-1:0];
        key_valid <= 1'b1;
      end
    end
  end

  crack_copy u_copy (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (cp_start),
    .sel       (win_idx),
    .rddata    (eng_dc_rddata),
    .dc_addr   (eng_dc_addr),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren),
    .hdr_wr    (cp_hdr),
    .done      (cp_done)
  );
endmodule
